// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding, default sizing and small op-decode helpers.
package muldiv_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_MUL_LAT = 5;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_MSUB  = 3'd6,
    OP_MSUBU = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  // Even op codes are the signed flavours.
  function automatic logic op_signed(input logic [2:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op[2:1] == 2'b01);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between a pipeline and the muldiv_iter unit.
interface muldiv_if import muldiv_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
);
  // Handshake: start is a one-cycle request honoured only on an edge where
  // busy=0 (otherwise dropped, never queued); once accepted busy stays high
  // until the completion edge, which raises done for exactly one cycle with
  // hi/lo already holding the result. cancel/we are plain strobes.
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             we;
  logic             whi;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel, we, whi, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel, we, whi, wdata,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/div_iter.sv
// Radix-2 restoring divider: one setup cycle for magnitudes, WIDTH
// iterations, and a combinational sign fix read out while the parent is in FIX.
module div_iter import muldiv_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             run,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] quo_out,
  output logic [WIDTH-1:0] rem_out
);

  localparam int NW = $clog2(WIDTH + 1);

  logic [NW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             neg_q;
  logic             neg_r;
  logic             dz;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  assign mag_a   = (sgn && a[WIDTH-1]) ? -a : a;
  assign mag_b   = (sgn && b[WIDTH-1]) ? -b : b;
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};
  // cnt==WIDTH on the edge performing the final quotient bit
  assign last    = run && (cnt == NW'(WIDTH));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
    end else if (!run) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      rem   <= '0;
      quo   <= mag_a;
      dvs   <= mag_b;
      neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= sgn && a[WIDTH-1];
      dz    <= (b == '0);
      cnt   <= NW'(1);
    end else begin
      if (!diff[WIDTH]) begin
        rem <= diff[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= shifted[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
      cnt <= cnt + NW'(1);
    end
  end

  // Divide by zero bypasses the sign fix: quotient all ones, remainder = a.
  assign quo_out = dz ? '1 : (neg_q ? -quo : quo);
  assign rem_out = dz ? a  : (neg_r ? -rem : rem);

endmodule

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (ops 4-7).
module muldiv_iter import muldiv_pkg::*; #(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic     clk,
  input  logic     clr_n,
  muldiv_if.slave  bus,
  output state_t   dbg_state
);

  localparam int CW = $clog2(MUL_LAT + 1);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               sgn_q;
  logic [CW-1:0]      mul_cnt;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               complete;
  logic               op_legal;
  logic               start_ok;
  logic               is_div;
  logic               div_last;
  logic [WIDTH-1:0]   div_q;
  logic [WIDTH-1:0]   div_r;
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mul_res;

`ifdef MULDIV_MADD_EN
  logic acc_q;
  logic sub_q;
  assign op_legal = 1'b1;
`else
  assign op_legal = ~bus.op[2];
`endif

  assign is_div   = op_is_div(bus.op);
  assign start_ok = bus.start && op_legal && (state == IDLE);

  always_comb begin
    state_nxt = state;
    complete  = 1'b0;
    case (state)
      IDLE: if (start_ok) state_nxt = is_div ? DIV : MUL;
      MUL: begin
        if (mul_cnt == '0) begin
          state_nxt = IDLE;
          complete  = 1'b1;
        end
      end
      DIV:  if (div_last) state_nxt = FIX;
      FIX: begin
        state_nxt = IDLE;
        complete  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    // A flush beats a completion landing on the same edge.
    if (bus.cancel && (state != IDLE)) begin
      state_nxt = IDLE;
      complete  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
`ifdef MULDIV_MADD_EN
      acc_q <= 1'b0;
      sub_q <= 1'b0;
`endif
    end else if (start_ok) begin
      a_q   <= bus.a;
      b_q   <= bus.b;
      sgn_q <= op_signed(bus.op);
`ifdef MULDIV_MADD_EN
      acc_q <= bus.op[2];
      sub_q <= bus.op[1];
`endif
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                              mul_cnt <= '0;
    else if (start_ok)                       mul_cnt <= CW'(MUL_LAT - 1);
    else if (state == MUL && mul_cnt != '0)  mul_cnt <= mul_cnt - CW'(1);
  end

  // Sign/zero-extended 2W-bit product: low 2W bits are exact either way.
  assign ext_a = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign ext_b = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign prod  = ext_a * ext_b;

`ifdef MULDIV_MADD_EN
  // HI/LO are read at completion; they cannot change while busy.
  assign mul_res = !acc_q ? prod :
                   sub_q  ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
`else
  assign mul_res = prod;
`endif

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk     (clk),
    .clr_n   (clr_n),
    .run     (state == DIV),
    .sgn     (sgn_q),
    .a       (a_q),
    .b       (b_q),
    .last    (div_last),
    .quo_out (div_q),
    .rem_out (div_r)
  );

  // Direct writes only land in IDLE, so they never collide with a completion.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (complete) begin
      if (state == FIX) {hi_q, lo_q} <= {div_r, div_q};
      else              {hi_q, lo_q} <= mul_res;
    end else if (bus.we && state == IDLE) begin
      if (bus.whi) hi_q <= bus.wdata;
      else         lo_q <= bus.wdata;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_nxt != IDLE);
      done_q <= complete;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboarded random/directed bench for muldiv_iter (WIDTH=32, MUL_LAT=5).
module tb_muldiv_iter;
  import muldiv_pkg::*;

  localparam int W   = 32;
  localparam int LAT = 5;

  logic   clk = 1'b0;
  logic   clr_n = 1'b0;
  state_t dbg_state;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_iter #(.WIDTH(W), .MUL_LAT(LAT)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] model_hl = '0;
  logic        prev_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit legal(input logic [2:0] op);
`ifdef MULDIV_MADD_EN
    return 1'b1;
`else
    return (op < 3'd4);
`endif
  endfunction

  function automatic bit is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] hl);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      OP_MULT:  return sa * sb;
      OP_MULTU: return ua * ub;
      OP_DIV, OP_DIVU: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (op == OP_DIV) begin
          q = sa / sb;
          r = sa % sb;
        end else begin
          q = longint'(ua / ub);
          r = longint'(ua % ub);
        end
        return {r[31:0], q[31:0]};
      end
      OP_MADD:  return hl + sa * sb;
      OP_MADDU: return hl + ua * ub;
      OP_MSUB:  return hl - sa * sb;
      OP_MSUBU: return hl - ua * ub;
      default:  return hl;
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 20));
      2: return 32'(-int'($urandom_range(1, 20)));
      default: begin
        case ($urandom_range(0, 3))
          0: return 32'h0000_0000;
          1: return 32'h8000_0000;
          2: return 32'hFFFF_FFFF;
          default: return 32'h7FFF_FFFF;
        endcase
      end
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [63:0] e;
    if (clr_n && bus.done) begin
      check("done_pulse_width", {63'b0, prev_done}, 64'd0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 hi=%h lo=%h expected no done", bus.hi, bus.lo);
      end else begin
        e = exp_q.pop_front();
        check("result_hilo", {bus.hi, bus.lo}, e);
      end
    end
    prev_done = clr_n && bus.done;
  end

  // ---------------- driver tasks (enter and leave just after a negedge) ----------------
  task automatic do_write(input logic whi, input logic [31:0] data);
    bus.we = 1'b1; bus.whi = whi; bus.wdata = data;
    @(negedge clk);
    bus.we = 1'b0;
    model_hl = whi ? {data, model_hl[31:0]} : {model_hl[63:32], data};
    check("mt_write", {bus.hi, bus.lo}, model_hl);
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic w_en, input logic w_hi, input logic [31:0] w_data);
    logic [63:0] e;
    int lat, exp_lat;
    if (w_en) model_hl = w_hi ? {w_data, model_hl[31:0]} : {model_hl[63:32], w_data};
    exp_lat = !legal(op) ? 0 : (is_div_op(op) ? W + 2 : LAT);
    e = legal(op) ? ref_model(op, a, b, model_hl) : model_hl;
    if (legal(op)) exp_q.push_back(e);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    bus.we = w_en; bus.whi = w_hi; bus.wdata = w_data;
    @(negedge clk);
    bus.start = 1'b0; bus.we = 1'b0;
    lat = 0;
    while (bus.busy === 1'b1 && lat < 200) begin
      lat++;
      @(negedge clk);
    end
    check($sformatf("busy_cycles_op%0d", op), 64'(lat), 64'(exp_lat));
    model_hl = e;
    if (!legal(op)) check("noop_hilo", {bus.hi, bus.lo}, model_hl);
  endtask

  task automatic do_cancel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int ncyc);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.we = 1'b1; bus.whi = $urandom_range(0, 1); bus.wdata = $urandom;
    @(negedge clk);
    bus.we = 1'b0;
    repeat (ncyc - 2) @(negedge clk);
    check("busy_before_cancel", {63'b0, bus.busy}, 64'd1);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("busy_after_cancel", {63'b0, bus.busy}, 64'd0);
    check("state_after_cancel", 64'(dbg_state), 64'(IDLE));
    check("hilo_after_cancel", {bus.hi, bus.lo}, model_hl);
    repeat (40) @(negedge clk);
    check("hilo_settled_cancel", {bus.hi, bus.lo}, model_hl);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0]  op;
    logic [31:0] ra, rb;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    bus.cancel = 1'b0; bus.we = 1'b0; bus.whi = 1'b0; bus.wdata = '0;

    repeat (3) @(negedge clk);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset_busy_done", {62'b0, bus.busy, bus.done}, 64'd0);
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    clr_n = 1'b1;
    @(negedge clk);

    do_op(OP_MULT,  32'hFFFF_FFFF, 32'd2, 0, 0, 0);
    do_op(OP_DIVU,  32'd100, 32'd7, 0, 0, 0);
    do_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 0, 0, 0);
    do_op(OP_DIVU,  32'd5, 32'd0, 0, 0, 0);
    do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    do_op(OP_DIV,   32'hFFFF_FFF9, 32'd0, 0, 0, 0);
    do_op(OP_DIV,   32'd7, 32'hFFFF_FFFE, 0, 0, 0);
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    do_op(OP_MULT,  32'd3, 32'd5, 1, 0, 32'h0000_ABCD);

`ifdef MULDIV_MADD_EN
    do_write(1'b0, 32'hFFFF_FFFF);
    do_write(1'b1, 32'h0);
    do_op(OP_MADD, 32'd1, 32'd1, 0, 0, 0);
    do_write(1'b1, 32'h0);
    do_write(1'b0, 32'h0);
    do_op(OP_MSUBU, 32'd1, 32'd1, 0, 0, 0);
    do_op(OP_MADDU, 32'd3, 32'd4, 1, 1, 32'h10);
    do_op(OP_MSUB, 32'hFFFF_FFFE, 32'd9, 0, 0, 0);
`else
    do_write(1'b0, 32'h1357_9BDF);
    do_op(OP_MADD, 32'd1, 32'd1, 0, 0, 0);
    do_op(OP_MSUBU, 32'd1, 32'd1, 0, 0, 0);
`endif

    do_cancel(OP_DIVU, 32'd100, 32'd7, 10);
    do_cancel(OP_MULT, 32'd3, 32'd3, LAT);
    do_op(OP_DIVU, 32'd1000, 32'd3, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      ra = rand_operand();
      rb = rand_operand();
      if ($urandom_range(0, 3) == 0)
        do_op(op, ra, rb, 1, 1'($urandom_range(0, 1)), $urandom);
      else
        do_op(op, ra, rb, 0, 0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    do_write(1'b0, 32'h1234_5678);
    bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd9; bus.b = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    check("async_reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("async_reset_busy", {63'b0, bus.busy}, 64'd0);
    @(negedge clk);
    clr_n = 1'b1;
    model_hl = '0;
    repeat (10) @(negedge clk);
    check("post_reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("post_reset_busy", {63'b0, bus.busy}, 64'd0);
    do_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_iter.md
MULDIV_ITER -- requirements
Module: muldiv_iter

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width; legal range 8..64.
REQ-002 Parameter MUL_LAT, default 5, multiply occupancy in cycles; legal range 1..16.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 clr_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  launch request, sampled at rising edge.
REQ-006 op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
REQ-007 a, b  input  WIDTH each  operands; a is the dividend and b the divisor.
REQ-008 cancel  input  1  aborts an in-flight operation (pipeline flush).
REQ-009 we  input  1  direct HI/LO write strobe (MTHI/MTLO).
REQ-010 whi  input  1  write target: 1 HI, 0 LO.
REQ-011 wdata  input  WIDTH  direct write data.
REQ-012 busy  output  1  registered; high while an operation occupies the unit.
REQ-013 done  output  1  registered one-cycle pulse on completion.
REQ-014 hi, lo  output  WIDTH each  architectural result registers.

Function
REQ-015 FSM states SHALL be IDLE, MUL, DIV, FIX; only IDLE accepts start.
REQ-016 start is ignored when busy=1.
REQ-017 On a start edge in IDLE, operands and op SHALL be latched; busy rises after that edge.
REQ-018 MULT/MULTU/MADD/MADDU/MSUB/MSUBU SHALL hold busy for exactly MUL_LAT cycles (IDLE->MUL->IDLE).
REQ-019 MULT/MULTU SHALL write {hi,lo} = a*b as a 2*WIDTH-bit product, signed or unsigned per op.
REQ-020 MADD(U)/MSUB(U) SHALL write {hi,lo} = {hi,lo} +/- a*b modulo 2^(2*WIDTH); {hi,lo} is sampled at completion, not at start.
REQ-021 DIV/DIVU SHALL use radix-2 restoring iteration, one quotient bit per cycle, with busy held for exactly WIDTH+2 cycles: 1 setup (magnitudes), WIDTH iterations in DIV, 1 sign fix in FIX.
REQ-022 Signed division SHALL truncate toward zero; the remainder takes the sign of the dividend.
REQ-023 Divide by zero SHALL give lo = all ones and hi = a, with no trap.
REQ-024 DIV of the most negative value by -1 SHALL give lo = the most negative value and hi = 0.
REQ-025 At the final edge of an operation, hi and lo update, busy falls, and done=1 for one cycle.
REQ-026 A new start is accepted on the cycle done is high (back-to-back, no bubble).
REQ-027 we=1 while busy=0 SHALL write wdata into HI or LO per whi at that edge.
REQ-028 we=1 while busy=1 is ignored.
REQ-029 A start and a we on the same IDLE edge SHALL apply the write first; a MADD/MSUB then uses the written value.
REQ-030 cancel=1 SHALL return the FSM to IDLE at that edge, leave hi/lo unchanged, drop busy, and suppress done.
REQ-031 If cancel and the completion edge coincide, cancel wins.
REQ-032 cancel while IDLE has no effect.

Reset
REQ-033 clr_n=0 SHALL immediately force state=IDLE, busy=0, done=0, hi=0, lo=0, and clear the iteration counter and datapath registers.
REQ-034 Reset mid-operation SHALL discard the operation; no done pulse follows reset release.

Configuration
REQ-035 Macro MULDIV_MADD_EN defined: ops 4-7 SHALL behave per REQ-020.
REQ-036 MULDIV_MADD_EN undefined: ops 4-7 SHALL be no-ops (start ignored, busy stays 0, hi/lo unchanged), and the accumulate adder SHALL be absent.

Structure
REQ-037 Shared package muldiv_pkg SHALL hold the op encodings, the FSM state encoding, and the default WIDTH/MUL_LAT constants.
REQ-038 Sub-module div_iter SHALL hold the restoring divider datapath: remainder/quotient shift registers, iteration counter and sign fix.
REQ-039 Multiply, accumulate, FSM and HI/LO registers SHALL reside in muldiv_iter.

Verification (WIDTH=32, MUL_LAT=5)
REQ-040 MULT a=0xFFFFFFFF, b=2 -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE, and a done pulse.
REQ-041 DIVU a=100, b=7 -> busy for 34 cycles, then lo=14, hi=2. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-042 DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5. DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
REQ-043 MTLO 0xFFFFFFFF and MTHI 0, then MADD a=1, b=1 -> hi=1, lo=0. MSUBU a=1, b=1 on hi:lo=0:0 -> hi=lo=0xFFFFFFFF.
REQ-044 DIVU launched, cancel at cycle 10 -> busy=0 next cycle, no done, hi/lo unchanged. A we issued while busy is ignored.
REQ-045 MULT launched, clr_n low at cycle 2 -> hi=lo=0 and busy=0 without waiting for a clock edge. Without MULDIV_MADD_EN, start with op=4 -> busy stays 0.
